// File: rtl/lzc_pkg.sv
// Shared defaults and FSM state type for the leading-zero-count feeder.
package lzc_pkg;

    localparam int unsigned WIDTH_DEF   = 8;
    localparam int unsigned WORD_DEF    = 4;
    localparam int unsigned OW_DEF      = WIDTH_DEF * WORD_DEF;
    localparam int unsigned ZW_DEF      = $clog2(OW_DEF) + 1;
    localparam int unsigned TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/lzc_expect.sv
// Reference leading-zero count of an operand; all-zero operand yields OW.
module lzc_expect
    import lzc_pkg::*;
#(
    parameter int unsigned OW = OW_DEF
) (
    input  logic [OW-1:0]      i_op,
    output logic [$clog2(OW):0] o_exp_c
);

    localparam int unsigned ZW = $clog2(OW) + 1;

    // Scan upward so the highest set bit makes the final assignment.
    always_comb begin
        o_exp_c = ZW'(OW);
        for (int i = 0; i < int'(OW); i++) begin
            if (i_op[i]) begin
                o_exp_c = ZW'(int'(OW) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/lzc_feeder.sv
// Streams an operand word-by-word to an external leading-zero counter and
// checks the returned count against a locally computed expectation.
module lzc_feeder
    import lzc_pkg::*;
#(
    parameter int unsigned width   = WIDTH_DEF,
    parameter int unsigned word    = WORD_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [width*word-1:0]           in_data,
    input  logic                            in_mode,
    output logic [width-1:0]                data,
    output logic                            Ivalid,
    output logic                            mode,
    input  logic [$clog2(width*word):0]     zeros,
    input  logic                            Ovalid,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [$clog2(width*word):0]     res_zeros,
    output logic                            res_mismatch,
    output logic                            res_timeout
);

    localparam int unsigned OW = width * word;
    localparam int unsigned ZW = $clog2(OW) + 1;
    localparam int unsigned IW = $clog2(word) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    state_e          r_state, w_state_nxt;
    logic [OW-1:0]   r_sh,    w_sh_nxt;
    logic            r_mode,  w_mode_nxt;
    logic [ZW-1:0]   r_exp,   w_exp_nxt;
    logic [IW-1:0]   r_idx,   w_idx_nxt;
    logic [TW-1:0]   r_tcnt,  w_tcnt_nxt;
    logic [ZW-1:0]   w_exp;
    logic [ZW-1:0]   w_res_zeros_nxt;
    logic            w_res_mis_nxt, w_res_tmo_nxt;
    logic [width-1:0] w_data_nxt;
    logic            w_ivalid_nxt, w_modeo_nxt, w_in_ready_nxt, w_res_valid_nxt;
    logic            w_accept, w_busy, w_tmo, w_last, w_done;

    lzc_expect #(.OW(OW)) u_expect (
        .i_op    (in_data),
        .o_exp_c (w_exp)
    );

    assign w_accept = (r_state == ST_IDLE) && in_valid && in_ready;
    assign w_busy   = (r_state == ST_SEND) || (r_state == ST_WAIT);
    assign w_tmo    = w_busy && (r_tcnt == TW'(TIMEOUT - 1));
    assign w_done   = w_busy && (Ovalid || w_tmo);
    // Turbo ends the stream on the first nonzero word, which is the current top of r_sh.
    assign w_last   = (r_idx == IW'(word - 1)) || (r_mode && (|r_sh[OW-1 -: width]));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)              w_state_nxt = ST_SEND;
            ST_SEND: if (w_done)                w_state_nxt = ST_RESP;
                     else if (w_last)           w_state_nxt = ST_WAIT;
            ST_WAIT: if (w_done)                w_state_nxt = ST_RESP;
            ST_RESP: if (res_valid && res_ready) w_state_nxt = ST_IDLE;
            default:                            w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath updates and next values for the registered outputs.
    always_comb begin
        w_sh_nxt        = r_sh;
        w_mode_nxt      = r_mode;
        w_exp_nxt       = r_exp;
        w_idx_nxt       = r_idx;
        w_tcnt_nxt      = r_tcnt;
        w_res_zeros_nxt = res_zeros;
        w_res_mis_nxt   = res_mismatch;
        w_res_tmo_nxt   = res_timeout;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_sh_nxt   = in_data;
                    w_mode_nxt = in_mode;
                    w_exp_nxt  = w_exp;
                    w_idx_nxt  = '0;
                    w_tcnt_nxt = '0;
                end
            end
            ST_SEND: begin
                w_tcnt_nxt = r_tcnt + 1'b1;
                if (!w_done && !w_last) begin
                    w_sh_nxt  = r_sh << width;
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            ST_WAIT: begin
                w_tcnt_nxt = r_tcnt + 1'b1;
            end
            default: ;
        endcase

        // A returned count beats a simultaneous timeout.
        if (w_busy && Ovalid) begin
            w_res_zeros_nxt = zeros;
            w_res_mis_nxt   = (zeros != r_exp);
            w_res_tmo_nxt   = 1'b0;
        end else if (w_tmo) begin
            w_res_zeros_nxt = r_exp;
            w_res_mis_nxt   = 1'b0;
            w_res_tmo_nxt   = 1'b1;
        end

        w_ivalid_nxt    = (w_state_nxt == ST_SEND);
        w_data_nxt      = w_ivalid_nxt ? w_sh_nxt[OW-1 -: width] : '0;
        w_modeo_nxt     = ((w_state_nxt == ST_SEND) || (w_state_nxt == ST_WAIT)) ? w_mode_nxt : 1'b0;
        w_in_ready_nxt  = (w_state_nxt == ST_IDLE);
        w_res_valid_nxt = (w_state_nxt == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh         <= '0;
            r_mode       <= 1'b0;
            r_exp        <= '0;
            r_idx        <= '0;
            r_tcnt       <= '0;
            in_ready     <= 1'b1;
            data         <= '0;
            Ivalid       <= 1'b0;
            mode         <= 1'b0;
            res_valid    <= 1'b0;
            res_zeros    <= '0;
            res_mismatch <= 1'b0;
            res_timeout  <= 1'b0;
        end else begin
            r_sh         <= w_sh_nxt;
            r_mode       <= w_mode_nxt;
            r_exp        <= w_exp_nxt;
            r_idx        <= w_idx_nxt;
            r_tcnt       <= w_tcnt_nxt;
            in_ready     <= w_in_ready_nxt;
            data         <= w_data_nxt;
            Ivalid       <= w_ivalid_nxt;
            mode         <= w_modeo_nxt;
            res_valid    <= w_res_valid_nxt;
            res_zeros    <= w_res_zeros_nxt;
            res_mismatch <= w_res_mis_nxt;
            res_timeout  <= w_res_tmo_nxt;
        end
    end

endmodule
